// File: rtl/user_io_pkg.sv
// Shared definitions for the user I/O status CSR block: CSR map, status FSM encoding,
// status-message field layout and the CSR request bundle.
package user_io_pkg;

   localparam logic [15:0] CSR_STAT     = 16'h0000;
   localparam logic [15:0] CSR_SCRATCH  = 16'h0008;
   localparam logic [15:0] CSR_STICKY   = 16'h0010;
   localparam logic [15:0] CSR_CTRL     = 16'h0018;
   localparam logic [15:0] CSR_CNT_BASE = 16'h0020;
   localparam logic [63:0] CSR_UNMAPPED = 64'hdeadbeefdeadbeef;

   localparam int SEQ_W = 16;

   typedef enum logic [1:0] {
      S_COUNT = 2'd0,
      S_PEND  = 2'd1,
      S_SEND  = 2'd2
   } stat_state_e;

   typedef struct packed {
      logic [15:0] addr;
      logic [63:0] data;
      logic        wr;
      logic        rd;
   } csr_req_t;

   // Message fields are NUM_LINKS wide, packed upward from bit 0; seq sits in the top 16 bits.
   function automatic int msg_lane_lo(input int n);  return 0;     endfunction
   function automatic int msg_chan_lo(input int n);  return n;     endfunction
   function automatic int msg_corr_lo(input int n);  return 2 * n; endfunction
   function automatic int msg_fatal_lo(input int n); return 3 * n; endfunction

endpackage

// File: rtl/user_io_link_stat.sv
// Per-link status: 2-flop sync of the async status wires, chan_up fall detect,
// saturating link-down counter and fatal/correctable sticky alarms.
// Change-detect outputs exist only when USER_IO_STAT_EVENT_EN is defined.
module user_io_link_stat
   import user_io_pkg::*;
#(
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 chan_up_a,
   input  logic                 lane_up_a,
   input  logic                 fatal_a,
   input  logic                 corr_a,
   input  logic                 cnt_clr,
   input  logic                 fatal_clr,
   input  logic                 corr_clr,
   output logic                 chan_up,
   output logic                 lane_up,
   output logic                 fatal_sticky,
   output logic                 corr_sticky,
`ifdef USER_IO_STAT_EVENT_EN
   output logic                 status_chg,
   output logic                 sticky_new,
`endif
   output logic [CNT_WIDTH-1:0] down_cnt
);

   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

   logic [1:0] chan_s, lane_s, fatal_s, corr_s;
   logic       chan_q;
   logic       down_evt;

   always_ff @(posedge clk) begin
      if (rst) begin
         chan_s       <= '0;
         lane_s       <= '0;
         fatal_s      <= '0;
         corr_s       <= '0;
         chan_q       <= 1'b0;
         fatal_sticky <= 1'b0;
         corr_sticky  <= 1'b0;
         down_cnt     <= '0;
      end else begin
         chan_s  <= {chan_s[0], chan_up_a};
         lane_s  <= {lane_s[0], lane_up_a};
         fatal_s <= {fatal_s[0], fatal_a};
         corr_s  <= {corr_s[0], corr_a};
         chan_q  <= chan_s[1];
         // an alarm still asserted wins over a W1C in the same cycle
         if (fatal_s[1])     fatal_sticky <= 1'b1;
         else if (fatal_clr) fatal_sticky <= 1'b0;
         if (corr_s[1])      corr_sticky  <= 1'b1;
         else if (corr_clr)  corr_sticky  <= 1'b0;
         if (cnt_clr)
            down_cnt <= down_evt ? CNT_WIDTH'(1) : '0;
         else if (down_evt && down_cnt != CNT_MAX)
            down_cnt <= down_cnt + CNT_WIDTH'(1);
      end
   end

   assign chan_up  = chan_s[1];
   assign lane_up  = lane_s[1];
   assign down_evt = chan_q & ~chan_s[1];

`ifdef USER_IO_STAT_EVENT_EN
   logic lane_q;
   always_ff @(posedge clk) begin
      if (rst) lane_q <= 1'b0;
      else     lane_q <= lane_s[1];
   end
   assign status_chg = (chan_q ^ chan_s[1]) | (lane_q ^ lane_s[1]);
   assign sticky_new = (fatal_s[1] & ~fatal_sticky) | (corr_s[1] & ~corr_sticky);
`endif

endmodule

// File: rtl/user_io_stat_csr.sv
// CSR decode and status-message FSM for the user I/O Aurora links.
// Define USER_IO_STAT_EVENT_EN to also emit a message on any status change.
module user_io_stat_csr
   import user_io_pkg::*;
#(
   parameter int NUM_LINKS       = 8,
   parameter int UIO_PORTS_WIDTH = 128,
   parameter int CNT_WIDTH       = 16,
   parameter int STAT_PERIOD     = 256
) (
   input  logic                       clk_per,
   input  logic                       reset_per,
   input  logic [15:0]                i_csr_addr,
   input  logic [63:0]                i_csr_data,
   input  logic                       i_csr_wr_vld,
   input  logic                       i_csr_rd_vld,
   output logic [63:0]                o_csr_data,
   output logic                       o_csr_rd_ack,
   input  logic [NUM_LINKS-1:0]       i_stat_chan_up,
   input  logic [NUM_LINKS-1:0]       i_stat_lane_up,
   input  logic [NUM_LINKS-1:0]       i_fatal_alarm,
   input  logic [NUM_LINKS-1:0]       i_corr_alarm,
   output logic [NUM_LINKS-1:0]       o_link_en,
   output logic                       o_uio_rs_vld,
   output logic [UIO_PORTS_WIDTH-1:0] o_uio_rs_data,
   input  logic                       i_uio_rs_afull
);

   localparam int PER_W    = $clog2(STAT_PERIOD);
   localparam int LANE_LO  = msg_lane_lo(NUM_LINKS);
   localparam int CHAN_LO  = msg_chan_lo(NUM_LINKS);
   localparam int CORR_LO  = msg_corr_lo(NUM_LINKS);
   localparam int FATAL_LO = msg_fatal_lo(NUM_LINKS);

   csr_req_t req;
   assign req = '{addr: i_csr_addr, data: i_csr_data, wr: i_csr_wr_vld, rd: i_csr_rd_vld};

   logic [NUM_LINKS-1:0]                chan_up, lane_up, fatal_sticky, corr_sticky;
   logic [NUM_LINKS-1:0]                cnt_hit, cnt_clr, fatal_clr, corr_clr;
   logic [NUM_LINKS-1:0][CNT_WIDTH-1:0] down_cnt;
   logic [63:0]                         scratch, rd_data;
   logic                                sticky_wr;
   logic                                evt;
`ifdef USER_IO_STAT_EVENT_EN
   logic [NUM_LINKS-1:0]                status_chg, sticky_new;
   assign evt = |status_chg | |sticky_new;
`else
   assign evt = 1'b0;
`endif

   assign sticky_wr = req.wr && (req.addr == CSR_STICKY);
   assign fatal_clr = {NUM_LINKS{sticky_wr}} & req.data[2*NUM_LINKS-1:NUM_LINKS];
   assign corr_clr  = {NUM_LINKS{sticky_wr}} & req.data[NUM_LINKS-1:0];
   assign cnt_clr   = {NUM_LINKS{req.wr}} & cnt_hit;

   for (genvar g = 0; g < NUM_LINKS; g++) begin : g_link
      user_io_link_stat #(.CNT_WIDTH(CNT_WIDTH)) u_link (
         .clk          (clk_per),
         .rst          (reset_per),
         .chan_up_a    (i_stat_chan_up[g]),
         .lane_up_a    (i_stat_lane_up[g]),
         .fatal_a      (i_fatal_alarm[g]),
         .corr_a       (i_corr_alarm[g]),
         .cnt_clr      (cnt_clr[g]),
         .fatal_clr    (fatal_clr[g]),
         .corr_clr     (corr_clr[g]),
         .chan_up      (chan_up[g]),
         .lane_up      (lane_up[g]),
         .fatal_sticky (fatal_sticky[g]),
         .corr_sticky  (corr_sticky[g]),
`ifdef USER_IO_STAT_EVENT_EN
         .status_chg   (status_chg[g]),
         .sticky_new   (sticky_new[g]),
`endif
         .down_cnt     (down_cnt[g])
      );
   end

   always_comb begin
      cnt_hit = '0;
      for (int i = 0; i < NUM_LINKS; i++)
         cnt_hit[i] = (req.addr == CSR_CNT_BASE + 16'(8 * i));
   end

   always_comb begin
      rd_data = CSR_UNMAPPED;
      case (req.addr)
         CSR_STAT:    rd_data = 64'({chan_up, lane_up});
         CSR_SCRATCH: rd_data = scratch;
         CSR_STICKY:  rd_data = 64'({fatal_sticky, corr_sticky});
         CSR_CTRL:    rd_data = 64'(o_link_en);
         default:
            for (int i = 0; i < NUM_LINKS; i++)
               if (cnt_hit[i]) rd_data = 64'(down_cnt[i]);
      endcase
   end

   always_ff @(posedge clk_per) begin
      if (reset_per) begin
         o_csr_rd_ack <= 1'b0;
         o_csr_data   <= '0;
         scratch      <= '0;
         o_link_en    <= '1;
      end else begin
         o_csr_rd_ack <= req.rd;
         if (req.rd)                             o_csr_data <= rd_data;
         if (req.wr && req.addr == CSR_SCRATCH)  scratch    <= req.data;
         if (req.wr && req.addr == CSR_CTRL)     o_link_en  <= req.data[NUM_LINKS-1:0];
      end
   end

   // Status message FSM; the period counter free-runs so late expiries are simply lost.
   stat_state_e              state, state_nxt;
   logic [PER_W-1:0]         per_cnt;
   logic                     per_exp;
   logic [SEQ_W-1:0]         seq;
   logic [UIO_PORTS_WIDTH-1:0] msg;

   assign per_exp = (per_cnt == PER_W'(STAT_PERIOD - 1));

   always_ff @(posedge clk_per) begin
      if (reset_per) state <= S_COUNT;
      else           state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_COUNT: if (per_exp || evt)   state_nxt = S_PEND;
         S_PEND:  if (!i_uio_rs_afull)  state_nxt = S_SEND;
         S_SEND:                        state_nxt = S_COUNT;
         default:                       state_nxt = S_COUNT;
      endcase
   end

   always_comb begin
      o_uio_rs_vld = (state == S_SEND);
   end

   always_comb begin
      msg                              = '0;
      msg[LANE_LO  +: NUM_LINKS]       = lane_up;
      msg[CHAN_LO  +: NUM_LINKS]       = chan_up;
      msg[CORR_LO  +: NUM_LINKS]       = corr_sticky;
      msg[FATAL_LO +: NUM_LINKS]       = fatal_sticky;
      msg[UIO_PORTS_WIDTH-1 -: SEQ_W]  = seq;
   end

   always_ff @(posedge clk_per) begin
      if (reset_per) begin
         per_cnt       <= '0;
         seq           <= '0;
         o_uio_rs_data <= '0;
      end else begin
         if ((state == S_COUNT && evt) || per_exp) per_cnt <= '0;
         else                                      per_cnt <= per_cnt + PER_W'(1);
         if (state == S_SEND) seq <= seq + SEQ_W'(1);
         if (state == S_PEND && !i_uio_rs_afull) o_uio_rs_data <= msg;
      end
   end

endmodule

// File: tb/tb_user_io_stat_csr.sv
// Scoreboard bench for user_io_stat_csr: CSR reads and status messages are checked by
// monitors against a register-level model kept in the bench.
module tb_user_io_stat_csr;
   localparam int N = 8, W = 128, CW = 2, SP = 256;
   localparam int CMAX = (1 << CW) - 1;

   logic          clk_per = 1'b0, reset_per = 1'b1;
   logic [15:0]   i_csr_addr = '0;
   logic [63:0]   i_csr_data = '0;
   logic          i_csr_wr_vld = 1'b0, i_csr_rd_vld = 1'b0;
   logic [63:0]   o_csr_data;
   logic          o_csr_rd_ack;
   logic [N-1:0]  i_stat_chan_up = '0, i_stat_lane_up = '0, i_fatal_alarm = '0, i_corr_alarm = '0;
   logic [N-1:0]  o_link_en;
   logic          o_uio_rs_vld;
   logic [W-1:0]  o_uio_rs_data;
   logic          i_uio_rs_afull = 1'b1;

   always #5 clk_per = ~clk_per;

   user_io_stat_csr #(.NUM_LINKS(N), .UIO_PORTS_WIDTH(W), .CNT_WIDTH(CW), .STAT_PERIOD(SP)) dut (
      .clk_per(clk_per), .reset_per(reset_per),
      .i_csr_addr(i_csr_addr), .i_csr_data(i_csr_data),
      .i_csr_wr_vld(i_csr_wr_vld), .i_csr_rd_vld(i_csr_rd_vld),
      .o_csr_data(o_csr_data), .o_csr_rd_ack(o_csr_rd_ack),
      .i_stat_chan_up(i_stat_chan_up), .i_stat_lane_up(i_stat_lane_up),
      .i_fatal_alarm(i_fatal_alarm), .i_corr_alarm(i_corr_alarm),
      .o_link_en(o_link_en), .o_uio_rs_vld(o_uio_rs_vld),
      .o_uio_rs_data(o_uio_rs_data), .i_uio_rs_afull(i_uio_rs_afull));

   int n_cmp = 0, n_bad = 0;
   int cyc = 0;
   always @(posedge clk_per) cyc <= cyc + 1;

   // reference model: register contents as the CSR map describes them
   logic [N-1:0]  m_chan = '0, m_lane = '0, m_fin = '0, m_cin = '0, m_fs = '0, m_cs = '0;
   logic [N-1:0]  m_len = '1;
   logic [63:0]   m_scratch = '0;
   int            m_cnt [N];
   int            last_chg = 0;
   bit            stat_blk = 1'b1;
   int            msg_cnt = 0;
   bit            vld_prev = 1'b0;

   typedef struct { logic [15:0] addr; logic [63:0] data; int due; } rd_exp_t;
   rd_exp_t rd_q[$];

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] m_rd(input logic [15:0] a);
      m_rd = 64'hdeadbeefdeadbeef;
      if (a == 16'h0)       m_rd = {48'd0, m_chan, m_lane};
      else if (a == 16'h8)  m_rd = m_scratch;
      else if (a == 16'h10) m_rd = {48'd0, m_fs, m_cs};
      else if (a == 16'h18) m_rd = {56'd0, m_len};
      else if (a >= 16'h20 && a < 16'(16'h20 + 8 * N) && a[2:0] == 3'd0)
         m_rd = 64'(m_cnt[(a - 16'h20) >> 3]);
   endfunction

   function automatic logic [W-17:0] m_body();
      m_body = '0;
      m_body[4*N-1:0] = {m_fs, m_cs, m_chan, m_lane};
   endfunction

   // monitors: CSR read scoreboard and status message checker
   always @(negedge clk_per) begin
      rd_exp_t e;
      if (!reset_per && o_csr_rd_ack) begin
         if (rd_q.size() == 0) check("rd_ack_unexpected", 128'(o_csr_rd_ack), 128'(0));
         else begin
            e = rd_q.pop_front();
            check("rd_ack_latency", 128'(cyc), 128'(e.due));
            check($sformatf("rd_data_%0h", e.addr), 128'(o_csr_data), 128'(e.data));
         end
      end
      if (!reset_per && o_uio_rs_vld) begin
         if (stat_blk) check("vld_while_afull", 128'(o_uio_rs_vld), 128'(0));
         check("msg_seq", 128'(o_uio_rs_data[W-1 -: 16]), 128'(16'(msg_cnt)));
         check("vld_one_cycle", 128'(vld_prev), 128'(0));
         if (cyc - last_chg >= 6) check("msg_body", 128'(o_uio_rs_data[W-17:0]), 128'(m_body()));
         msg_cnt++;
      end
      vld_prev = o_uio_rs_vld;
   end

   task automatic set_status(input logic [N-1:0] c, l, f, r);
      @(negedge clk_per);
      for (int i = 0; i < N; i++)
         if (m_chan[i] && !c[i] && m_cnt[i] < CMAX) m_cnt[i]++;
      m_chan = c; m_lane = l; m_fin = f; m_cin = r;
      m_fs |= f; m_cs |= r;
      i_stat_chan_up = c; i_stat_lane_up = l; i_fatal_alarm = f; i_corr_alarm = r;
      last_chg = cyc;
      repeat (4) @(negedge clk_per);
   endtask

   task automatic csr_rd(input logic [15:0] a);
      rd_exp_t e;
      @(negedge clk_per);
      e.addr = a; e.data = m_rd(a); e.due = cyc + 1;
      rd_q.push_back(e);
      i_csr_addr = a; i_csr_rd_vld = 1'b1;
      @(negedge clk_per);
      i_csr_rd_vld = 1'b0;
   endtask

   task automatic csr_wr(input logic [15:0] a, input logic [63:0] d);
      @(negedge clk_per);
      if (a == 16'h8) m_scratch = d;
      else if (a == 16'h10) begin
         m_fs = (m_fs & ~d[2*N-1:N]) | m_fin;
         m_cs = (m_cs & ~d[N-1:0]) | m_cin;
      end else if (a == 16'h18) m_len = d[N-1:0];
      else if (a >= 16'h20 && a < 16'(16'h20 + 8 * N) && a[2:0] == 3'd0)
         m_cnt[(a - 16'h20) >> 3] = 0;
      i_csr_addr = a; i_csr_data = d; i_csr_wr_vld = 1'b1;
      last_chg = cyc;
      @(negedge clk_per);
      i_csr_wr_vld = 1'b0;
      check("link_en", 128'(o_link_en), 128'(m_len));
   endtask

   task automatic wait_vld(input int bound, output int n);
      n = 0;
      while (n <= bound) begin
         @(negedge clk_per);
         n++;
         if (o_uio_rs_vld) break;
      end
   endtask

   logic [15:0] addrs [14] = '{16'h00, 16'h08, 16'h10, 16'h18, 16'h20, 16'h28, 16'h30,
                               16'h38, 16'h40, 16'h58, 16'h60, 16'h04, 16'h1000, 16'hffff};

   initial begin
      int n;
      for (int i = 0; i < N; i++) m_cnt[i] = 0;
      repeat (3) @(negedge clk_per);
      check("rst_rd_ack",  128'(o_csr_rd_ack),  128'(0));
      check("rst_csr_data", 128'(o_csr_data),   128'(0));
      check("rst_vld",     128'(o_uio_rs_vld),  128'(0));
      check("rst_msg",     128'(o_uio_rs_data), 128'(0));
      check("rst_link_en", 128'(o_link_en),     128'({N{1'b1}}));
      reset_per = 1'b0;

      // control / unmapped reads
      csr_rd(16'h18); csr_rd(16'h40); csr_rd(16'h60); csr_rd(16'h04);
      csr_wr(16'h8, 64'h0123456789abcdef); csr_rd(16'h8);
      csr_wr(16'h18, 64'hffff_ffff_ffff_ff5a); csr_rd(16'h18);
      set_status('1, '1, '0, '0);
      csr_rd(16'h0);

      // link 3: three down events then clear
      repeat (3) begin
         set_status(m_chan & ~8'h08, m_lane, '0, '0);
         set_status(m_chan | 8'h08, m_lane, '0, '0);
      end
      csr_rd(16'h38);
      csr_wr(16'h38, 64'h5); csr_rd(16'h38);

      // link 0: saturation, then clear coinciding with a down event
      repeat (5) begin
         set_status(m_chan & ~8'h01, m_lane, '0, '0);
         set_status(m_chan | 8'h01, m_lane, '0, '0);
      end
      csr_rd(16'h20);
      @(negedge clk_per);
      m_chan[0] = 1'b0; i_stat_chan_up[0] = 1'b0; last_chg = cyc;
      repeat (2) @(negedge clk_per);
      i_csr_addr = 16'h20; i_csr_data = '0; i_csr_wr_vld = 1'b1; m_cnt[0] = 1; last_chg = cyc;
      @(negedge clk_per);
      i_csr_wr_vld = 1'b0;
      repeat (4) @(negedge clk_per);
      csr_rd(16'h20);

      // sticky: pulse, then W1C against a held alarm, then W1C after release
      set_status(m_chan, m_lane, '0, 8'h20);
      set_status(m_chan, m_lane, '0, '0);
      csr_rd(16'h10);
      set_status(m_chan, m_lane, 8'h02, 8'h20);
      csr_wr(16'h10, 64'h0220); csr_rd(16'h10);
      set_status(m_chan, m_lane, '0, '0);
      csr_wr(16'h10, 64'h0220); csr_rd(16'h10);

      // afull held since reset: release and expect seq 0 promptly, then seq 1
      while (cyc < 620) @(negedge clk_per);
      stat_blk = 1'b0; i_uio_rs_afull = 1'b0;
      wait_vld(4, n);
      check("afull_release_msg", 128'(n <= 3), 128'(1));
      wait_vld(SP + 10, n);
      check("second_msg", 128'(n <= SP + 10), 128'(1));

      // lane_up[0] rise right after a message
      set_status(m_chan, m_lane & ~8'h01, '0, '0);
      wait_vld(SP + 20, n);
      check("sync_msg", 128'(n <= SP + 20), 128'(1));
      @(negedge clk_per);
      m_lane[0] = 1'b1; i_stat_lane_up[0] = 1'b1; last_chg = cyc;
      wait_vld(SP + 20, n);
`ifdef USER_IO_STAT_EVENT_EN
      check("event_msg_latency", 128'(n <= 6), 128'(1));
`else
      check("periodic_only", 128'(n > 20 && n <= SP + 20), 128'(1));
`endif

      // randomized mix of status changes and CSR traffic
      for (int k = 0; k < 300; k++) begin
         int op;
         logic [15:0] a;
         op = $urandom_range(0, 9);
         a  = addrs[$urandom_range(0, 13)];
         if (op < 3)
            set_status(N'($urandom), N'($urandom),
                       ($urandom_range(0, 3) == 0) ? N'($urandom) : '0,
                       ($urandom_range(0, 3) == 0) ? N'($urandom) : '0);
         else if (op < 6) csr_wr(a, {$urandom, $urandom});
         else             csr_rd(a);
      end

      for (int k = 0; k < 20 && rd_q.size() != 0; k++) @(negedge clk_per);
      check("rd_q_drained", 128'(rd_q.size()), 128'(0));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

endmodule
